// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and control bundle for the multicycle MIPS controller.
// Build option: define MIPS_CTRL_ADDI_EN to make addi (0x08) a supported opcode.
package mips_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [ST_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADDR   = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTE   = 4'd6,
        S_RCOMPLETE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDIEXEC  = 4'd10,
        S_ADDIWB    = 4'd11
    } state_t;

    // Raw per-state control word; FETCH-time ir_write/pc_write are later qualified by memory ready.
    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             ir_write;
        logic [SEL_W-1:0] pc_source;
        logic [SEL_W-1:0] alu_op;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic             reg_write;
        logic             reg_dst;
    } ctrl_t;

    // Opcodes that DECODE dispatches; anything else raises Illegal.
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: op_supported = 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI: op_supported = 1'b1;
`endif
            default: op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State-to-control-word decoder for the multicycle MIPS controller (Moore outputs).
// Build option: MIPS_CTRL_ADDI_EN adds the ADDIEXEC/ADDIWB decodes.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state datapath controls; anything not set here stays 0, including unused encodings.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RCOMPLETE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with memory-ready stalls.
// Build option: define MIPS_CTRL_ADDI_EN to support addi (Op 0x08) via ADDIEXEC/ADDIWB.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned STATE_WIDTH   = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OP_W-1:0]        Op,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemtoReg,
    output logic                   IRWrite,
    output logic [SEL_W-1:0]       PCSource,
    output logic [SEL_W-1:0]       ALUOp,
    output logic                   ALUSrcA,
    output logic [SEL_W-1:0]       ALUSrcB,
    output logic                   RegWrite,
    output logic                   RegDst,
    output logic                   Illegal,
    output logic [STATE_WIDTH-1:0] State
);

    state_t state;
    state_t state_nx;
    ctrl_t  ctrl;
    logic   mem_rdy;

    assign mem_rdy = USE_MEM_READY ? MemReady : 1'b1;

    // State register; reset lands in FETCH immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: Op is only consulted in DECODE and MEMADDR.
    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:    state_nx = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nx = S_MEMADDR;
                    OP_RTYPE:     state_nx = S_EXECUTE;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_J:         state_nx = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_nx = S_ADDIEXEC;
`endif
                    default:      state_nx = S_FETCH;
                endcase
            end
            S_MEMADDR:  state_nx = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nx = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nx = S_FETCH;
            S_MEMWRITE: state_nx = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_nx = S_RCOMPLETE;
            S_RCOMPLETE: state_nx = S_FETCH;
            S_BRANCH:   state_nx = S_FETCH;
            S_JUMP:     state_nx = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDIEXEC: state_nx = S_ADDIWB;
            S_ADDIWB:   state_nx = S_FETCH;
`endif
            default:    state_nx = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    // Final outputs: FETCH strobes wait for memory, and reset silences every enable.
    always_comb begin
        PCWrite     = rst_n & ctrl.pc_write & ((state != S_FETCH) | mem_rdy);
        IRWrite     = rst_n & ctrl.ir_write & mem_rdy;
        PCWriteCond = rst_n & ctrl.pc_write_cond;
        MemRead     = rst_n & ctrl.mem_read;
        MemWrite    = rst_n & ctrl.mem_write;
        RegWrite    = rst_n & ctrl.reg_write;
        Illegal     = rst_n & (state == S_DECODE) & ~op_supported(Op);
        IorD        = ctrl.iord;
        MemtoReg    = ctrl.mem_to_reg;
        PCSource    = ctrl.pc_source;
        ALUOp       = ctrl.alu_op;
        ALUSrcA     = ctrl.alu_src_a;
        ALUSrcB     = ctrl.alu_src_b;
        RegDst      = ctrl.reg_dst;
        State       = STATE_WIDTH'(state);
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed plus random instruction streams
// checked against a per-instruction reference model of states, controls and pulse counts.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, Illegal;
    logic [3:0] State;
    logic [16:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;
    int irw_cnt, pcw_cnt, mw_cnt, rw_cnt, ill_cnt;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .Illegal     (Illegal),
        .State       (State)
    );

    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal};

    function automatic bit legal(input logic [5:0] op);
        legal = op inside {6'h00, 6'h02, 6'h04, 6'h23, 6'h2B};
`ifdef MIPS_CTRL_ADDI_EN
        if (op == 6'h08) legal = 1'b1;
`endif
    endfunction

    function automatic bit rbit();
        rbit = 1'($urandom_range(1));
    endfunction

    // Expected control vector for one cycle, from the controller's output table.
    function automatic logic [16:0] exp_out(input int st, input bit mr, input logic [5:0] op,
                                            input bit rst);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
        bit srca = 0, rw = 0, rd = 0, ill = 0;
        bit [1:0] pcs = 0, aop = 0, srcb = 0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; ill = !legal(op); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
`ifdef MIPS_CTRL_ADDI_EN
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; end
`endif
            default: ;
        endcase
        if (rst) begin
            pcw = 0; pcwc = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; ill = 0;
        end
        exp_out = {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, srca, srcb, rw, rd, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic step(input logic [5:0] op, input bit mr, input int st);
        Op       = op;
        MemReady = mr;
        @(negedge clk);
        check("state", 32'(State), 32'(st));
        check("controls", 32'(obs), 32'(exp_out(st, mr, op, 1'b0)));
        irw_cnt += int'(IRWrite);
        pcw_cnt += int'(PCWrite);
        mw_cnt  += int'(MemWrite);
        rw_cnt  += int'(RegWrite);
        ill_cnt += int'(Illegal);
        @(posedge clk);
        #1;
    endtask

    // Reference model: builds the cycle-by-cycle state walk for one instruction.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        int         sq[$];
        bit         mq[$];
        logic [5:0] oq[$];
        int exp_rw = 0, exp_mw = 0, exp_pcw = 1, exp_ill = 0;
        for (int i = 0; i < fstall; i++) begin
            sq.push_back(0); mq.push_back(1'b0); oq.push_back(6'($urandom_range(63)));
        end
        sq.push_back(0); mq.push_back(1'b1); oq.push_back(op);
        sq.push_back(1); mq.push_back(rbit()); oq.push_back(op);
        if (op == 6'h23 || op == 6'h2B) begin
            sq.push_back(2); mq.push_back(rbit()); oq.push_back(op);
            for (int i = 0; i <= mstall; i++) begin
                sq.push_back(op == 6'h23 ? 3 : 5);
                mq.push_back(i == mstall);
                oq.push_back(op);
            end
            if (op == 6'h23) begin
                sq.push_back(4); mq.push_back(rbit()); oq.push_back(op);
                exp_rw = 1;
            end else begin
                exp_mw = mstall + 1;
            end
        end else if (op == 6'h00) begin
            sq.push_back(6); mq.push_back(rbit()); oq.push_back(op);
            sq.push_back(7); mq.push_back(rbit()); oq.push_back(op);
            exp_rw = 1;
        end else if (op == 6'h04) begin
            sq.push_back(8); mq.push_back(rbit()); oq.push_back(op);
        end else if (op == 6'h02) begin
            sq.push_back(9); mq.push_back(rbit()); oq.push_back(op);
            exp_pcw = 2;
        end else if (legal(op)) begin
            sq.push_back(10); mq.push_back(rbit()); oq.push_back(op);
            sq.push_back(11); mq.push_back(rbit()); oq.push_back(op);
            exp_rw = 1;
        end else begin
            exp_ill = 1;
        end
        irw_cnt = 0; pcw_cnt = 0; mw_cnt = 0; rw_cnt = 0; ill_cnt = 0;
        foreach (sq[i]) step(oq[i], mq[i], sq[i]);
        check("irwrite_pulses", 32'(irw_cnt), 32'd1);
        check("pcwrite_cycles", 32'(pcw_cnt), 32'(exp_pcw));
        check("memwrite_cycles", 32'(mw_cnt), 32'(exp_mw));
        check("regwrite_cycles", 32'(rw_cnt), 32'(exp_rw));
        check("illegal_pulses", 32'(ill_cnt), 32'(exp_ill));
    endtask

    logic [5:0] op_tab [8];

    initial begin
        op_tab[0] = 6'h23; op_tab[1] = 6'h2B; op_tab[2] = 6'h00; op_tab[3] = 6'h04;
        op_tab[4] = 6'h02; op_tab[5] = 6'h08; op_tab[6] = 6'h3F; op_tab[7] = 6'h00;

        rst_n    = 1'b0;
        Op       = 6'h00;
        MemReady = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(State), 32'd0);
        check("reset_controls", 32'(obs), 32'(exp_out(0, 1'b0, 6'h00, 1'b1)));
        MemReady = 1'b1;
        #1;
        check("reset_ready_controls", 32'(obs), 32'(exp_out(0, 1'b1, 6'h00, 1'b1)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed instructions
        run_instr(6'h23, 0, 0);
        run_instr(6'h00, 0, 0);
        run_instr(6'h04, 0, 0);
        run_instr(6'h2B, 3, 2);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h08, 0, 0);
        run_instr(6'h02, 1, 0);
        run_instr(6'h23, 2, 3);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(3) == 0) op = 6'($urandom_range(63));
            else                        op = op_tab[$urandom_range(7)];
            run_instr(op, int'($urandom_range(3)), int'($urandom_range(3)));
        end

        // Reset while a store is stalled in MEMWRITE
        step(6'h2B, 1'b1, 0);
        step(6'h2B, rbit(), 1);
        step(6'h2B, rbit(), 2);
        step(6'h2B, 1'b0, 5);
        MemReady = 1'b1;
        #1;
        check("memwrite_before_reset", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwrite_reset_state", 32'(State), 32'd0);
        check("midwrite_reset_memwrite", 32'(MemWrite), 32'd0);
        check("midwrite_reset_controls", 32'(obs), 32'(exp_out(0, 1'b1, 6'h2B, 1'b1)));
        @(posedge clk);
        #1;
        check("held_reset_state", 32'(State), 32'd0);
        rst_n = 1'b1;
        run_instr(6'h23, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
